vga_text_mem: RTL



---
 rtl/vga_text_mem.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vga_text_mem.sv
// Text-buffer SRAM responder: renderer reads always win the next SRAM cycle,
// CPU Wishbone accesses fill the remaining cycles. Every access is one cycle long.
module vga_text_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:1] csr_adr_i,
    input  logic        csr_stb_i,
    output logic [15:0] csr_dat_o,
    input  logic [16:1] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic [15:0] sram_addr_,
    inout  wire  [15:0] sram_data_,
    output logic        sram_we_n_,
    output logic        sram_oe_n_,
    output logic        sram_ce_n_,
    output logic [1:0]  sram_bw_n_
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CSR_RD = 2'd1;
    localparam logic [1:0] S_CPU_RD = 2'd2;
    localparam logic [1:0] S_CPU_WR = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_addr;
    logic        r_we_n;
    logic        r_oe_n;
    logic        r_ce_n;
    logic [1:0]  r_bw_n;
    logic        r_drive;
    logic [15:0] r_wdata;
    logic [15:0] r_csr_dat;
    logic [15:0] r_wb_dat;
    logic        r_ack;

    logic        w_cpu_req;
    logic        w_cpu_done;
    logic        w_cpu_start;
    logic [1:0]  w_state_nxt;
    logic [15:0] w_addr_nxt;
    logic        w_we_n_nxt;
    logic        w_oe_n_nxt;
    logic        w_ce_n_nxt;
    logic [1:0]  w_bw_n_nxt;
    logic        w_drive_nxt;
    logic [15:0] w_wdata_nxt;

    // A CPU access that is completing on this edge must not restart before its ack is visible.
    assign w_cpu_req   = wb_cyc_i & wb_stb_i;
    assign w_cpu_done  = (r_state == S_CPU_RD) || (r_state == S_CPU_WR);
    assign w_cpu_start = w_cpu_req & ~r_ack & ~w_cpu_done;

    // Pick the access that starts on the coming edge and its SRAM control values.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = r_addr;
        w_we_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_ce_n_nxt  = 1'b1;
        w_bw_n_nxt  = 2'b11;
        w_drive_nxt = 1'b0;
        w_wdata_nxt = r_wdata;
        if (csr_stb_i) begin
            w_state_nxt = S_CSR_RD;
            w_addr_nxt  = csr_adr_i;
            w_oe_n_nxt  = 1'b0;
            w_ce_n_nxt  = 1'b0;
            w_bw_n_nxt  = 2'b00;
        end else if (w_cpu_start) begin
            w_addr_nxt = wb_adr_i;
            w_ce_n_nxt = 1'b0;
            w_bw_n_nxt = ~wb_sel_i;
            if (wb_we_i) begin
                w_state_nxt = S_CPU_WR;
                w_we_n_nxt  = 1'b0;
                w_drive_nxt = 1'b1;
                w_wdata_nxt = wb_dat_i;
            end else begin
                w_state_nxt = S_CPU_RD;
                w_oe_n_nxt  = 1'b0;
            end
        end else begin
            w_state_nxt = S_IDLE;
        end
    end

    // Register state and every SRAM pin, including the data bus enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= 16'h0000;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ce_n  <= 1'b1;
            r_bw_n  <= 2'b11;
            r_drive <= 1'b0;
            r_wdata <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_we_n  <= w_we_n_nxt;
            r_oe_n  <= w_oe_n_nxt;
            r_ce_n  <= w_ce_n_nxt;
            r_bw_n  <= w_bw_n_nxt;
            r_drive <= w_drive_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // Capture read data and raise the ack as the current access completes; an aborted master gets no ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csr_dat <= 16'h0000;
            r_wb_dat  <= 16'h0000;
            r_ack     <= 1'b0;
        end else begin
            case (r_state)
                S_CSR_RD: begin
                    r_csr_dat <= sram_data_;
                    r_ack     <= 1'b0;
                end
                S_CPU_RD: begin
                    r_wb_dat <= sram_data_;
                    r_ack    <= w_cpu_req;
                end
                S_CPU_WR: begin
                    r_ack <= w_cpu_req;
                end
                default: begin
                    r_ack <= 1'b0;
                end
            endcase
        end
    end

    assign sram_data_ = r_drive ? r_wdata : 16'bzzzz_zzzz_zzzz_zzzz;
    assign sram_addr_ = r_addr;
    assign sram_we_n_ = r_we_n;
    assign sram_oe_n_ = r_oe_n;
    assign sram_ce_n_ = r_ce_n;
    assign sram_bw_n_ = r_bw_n;
    assign csr_dat_o  = r_csr_dat;
    assign wb_dat_o   = r_wb_dat;
    assign wb_ack_o   = r_ack;

endmodule
